// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: samples debounced data on clock falls and emits checked bytes.
// Optional inter-edge watchdog is enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx #(
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic       ps2_clk_q;
  logic [7:0] sh_q, sh_d;
  logic       par_q, par_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       fall_s;
  logic       to_expired_s;

  // Byte plus parity bit must carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

  assign fall_s = ps2_clk_q & ~ps2_clk;

`ifdef PS2_RX_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;

  // Watchdog counts idle cycles between falls while a frame is in progress.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if ((state_q == ST_IDLE) || fall_s) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign to_expired_s = (state_q != ST_IDLE) && (&to_cnt_q) && !fall_s;
`else
  assign to_expired_s = 1'b0;
  if (TIMEOUT_W == 32'd0) begin : g_no_watchdog
  end
`endif

  // Frame FSM: advances only on a clock fall unless the watchdog expires.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    par_d     = par_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (to_expired_s) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end else if (fall_s) begin
      case (state_q)
        ST_IDLE: begin
          if (!ps2_data) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DATA: begin
          sh_d      = {ps2_data, sh_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_PARITY: begin
          par_d   = ps2_data;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if (ps2_data && odd_parity_ok(sh_q, par_q)) begin
            data_d  = sh_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, datapath and registered strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ps2_clk_q <= 1'b1;
      sh_q      <= 8'h00;
      par_q     <= 1'b0;
      bit_cnt_q <= 3'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ps2_clk_q <= ps2_clk;
      sh_q      <= sh_d;
      par_q     <= par_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule
